instr_mem_loader: RTL and testbench

//  Parametrised instruction memory with a burst loader and a pipelined fetch port.

---
 rtl/instr_mem_loader.sv | 190 +++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory with NOP scrub, burst loader and pipelined fetch port
module instr_mem_loader #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] NOP      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic [DATA_W-1:0] instruction,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_SCRUB = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_scrub_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_ld_done;
  logic              r_ld_ready;
  logic              r_fetch_ready;
  logic              r_busy;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_fetch_acc;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_word;

  // Writes come only from SCRUB and LOAD, so they never collide with an accepted fetch.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_scrub_ptr;
    w_wdata = NOP;
    case (r_state)
      S_SCRUB: w_we = 1'b1;
      S_LOAD: begin
        w_we    = ld_valid && ({1'b0, r_wr_ptr} < DEPTH_W);
        w_waddr = r_wr_ptr;
        w_wdata = ld_data;
      end
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_SCRUB;
      r_scrub_ptr   <= '0;
      r_wr_ptr      <= '0;
      r_cnt         <= '0;
      r_ld_done     <= 1'b0;
      r_ld_ready    <= 1'b0;
      r_fetch_ready <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        S_SCRUB: begin
          if (r_scrub_ptr == LAST_ADDR) begin
            r_state       <= S_IDLE;
            r_fetch_ready <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_scrub_ptr <= r_scrub_ptr + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (ld_start) begin
            r_wr_ptr <= ld_base;
            r_cnt    <= ld_len;
            if (ld_len == '0) begin
              r_ld_done <= 1'b1;
            end else begin
              r_state       <= S_LOAD;
              r_ld_ready    <= 1'b1;
              r_fetch_ready <= 1'b0;
              r_busy        <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_W'(1);
            r_cnt    <= r_cnt - (ADDR_W + 1)'(1);
            if (r_cnt == (ADDR_W + 1)'(1)) begin
              r_state       <= S_IDLE;
              r_ld_ready    <= 1'b0;
              r_fetch_ready <= 1'b1;
              r_busy        <= 1'b0;
              r_ld_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_SCRUB;
        end
      endcase
    end
  end

  assign ld_ready    = r_ld_ready;
  assign ld_done     = r_ld_done;
  assign fetch_ready = r_fetch_ready;
  assign busy        = r_busy;

  assign w_fetch_acc = fetch_req && r_fetch_ready;
  assign w_in_range  = ({1'b0, fetch_addr} < DEPTH_W);
  assign w_rd_word   = w_in_range ? r_mem[fetch_addr] : NOP;

  // First fetch stage: the array is read at the acceptance edge; data holds until the next accept.
  logic              r_p1_valid;
  logic              r_p1_err;
  logic [DATA_W-1:0] r_p1_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1_valid <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p1_data  <= '0;
    end else begin
      r_p1_valid <= w_fetch_acc;
      r_p1_err   <= w_fetch_acc && !w_in_range;
      if (w_fetch_acc) begin
        r_p1_data <= w_rd_word;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_p2_valid;
      logic              r_p2_err;
      logic [DATA_W-1:0] r_p2_data;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_p2_valid <= 1'b0;
          r_p2_err   <= 1'b0;
          r_p2_data  <= '0;
        end else begin
          r_p2_valid <= r_p1_valid;
          r_p2_err   <= r_p1_err;
          if (r_p1_valid) begin
            r_p2_data <= r_p1_data;
          end
        end
      end

      assign fetch_valid = r_p2_valid;
      assign fetch_err   = r_p2_err;
      assign instruction = r_p2_data;
    end else begin : g_lat1
      assign fetch_valid = r_p1_valid;
      assign fetch_err   = r_p1_err;
      assign instruction = r_p1_data;
    end
  endgenerate

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed bench for instr_mem_loader: three configurations driven in lockstep
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_start;
  logic [7:0]  ld_base;
  logic [8:0]  ld_len;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        fetch_req;
  logic [7:0]  fetch_addr;

  logic        a_ld_ready, a_ld_done, a_fetch_ready, a_fetch_valid, a_fetch_err, a_busy;
  logic        b_ld_ready, b_ld_done, b_fetch_ready, b_fetch_valid, b_fetch_err, b_busy;
  logic        c_ld_ready, c_ld_done, c_fetch_ready, c_fetch_valid, c_fetch_err, c_busy;
  logic [15:0] a_instr, b_instr, c_instr;

  always #5 clk = ~clk;

  // a: defaults, b: DEPTH=200, c: READ_LAT=2
  instr_mem_loader u_a (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(a_ld_ready), .ld_done(a_ld_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(a_fetch_ready),
    .fetch_valid(a_fetch_valid), .fetch_err(a_fetch_err), .instruction(a_instr), .busy(a_busy)
  );

  instr_mem_loader #(.DEPTH(200)) u_b (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(b_ld_ready), .ld_done(b_ld_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(b_fetch_ready),
    .fetch_valid(b_fetch_valid), .fetch_err(b_fetch_err), .instruction(b_instr), .busy(b_busy)
  );

  instr_mem_loader #(.READ_LAT(2)) u_c (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(c_ld_ready), .ld_done(c_ld_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(c_fetch_ready),
    .fetch_valid(c_fetch_valid), .fetch_err(c_fetch_err), .instruction(c_instr), .busy(c_busy)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] a_d;
    logic        a_e;
    logic [15:0] b_d;
    logic        b_e;
  } vec_t;

  vec_t        vecs [14];
  logic [15:0] words [4];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic scrub_wait(input string tag);
    int ca, cb, cc, dones;
    ca = 0; cb = 0; cc = 0; dones = 0;
    for (int t = 0; t < 1000 && (a_busy || b_busy || c_busy); t++) begin
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (c_busy) cc++;
      if (a_ld_done || b_ld_done || c_ld_done) dones++;
      @(negedge clk);
    end
    check({tag, "_busy_a"}, ca, 256);
    check({tag, "_busy_b"}, cb, 200);
    check({tag, "_busy_c"}, cc, 256);
    check({tag, "_no_done"}, dones, 0);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi + 2; i++) begin
      @(negedge clk);
      if (i - 1 >= lo && i - 1 <= hi) begin
        check($sformatf("a_valid[%0d]", i - 1), a_fetch_valid, 1);
        check($sformatf("a_data[%0d]", i - 1), a_instr, vecs[i-1].a_d);
        check($sformatf("a_err[%0d]", i - 1), a_fetch_err, vecs[i-1].a_e);
        check($sformatf("b_valid[%0d]", i - 1), b_fetch_valid, 1);
        check($sformatf("b_data[%0d]", i - 1), b_instr, vecs[i-1].b_d);
        check($sformatf("b_err[%0d]", i - 1), b_fetch_err, vecs[i-1].b_e);
      end else if (i - 1 > hi) begin
        check($sformatf("a_valid_drop[%0d]", i - 1), a_fetch_valid, 0);
      end
      if (i - 2 >= lo && i - 2 <= hi) begin
        check($sformatf("c_valid[%0d]", i - 2), c_fetch_valid, 1);
        check($sformatf("c_data[%0d]", i - 2), c_instr, vecs[i-2].a_d);
        check($sformatf("c_err[%0d]", i - 2), c_fetch_err, vecs[i-2].a_e);
      end else if (i == lo + 1) begin
        check($sformatf("c_not_yet[%0d]", lo), c_fetch_valid, 0);
      end
      if (i <= hi) begin
        fetch_req  = 1'b1;
        fetch_addr = vecs[i].addr;
      end else begin
        fetch_req = 1'b0;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [7:0] base, input int len, input logic bubble);
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = 9'(len);
    @(negedge clk);
    ld_start = 1'b0;
    check({tag, "_ld_ready"}, a_ld_ready, 1);
    check({tag, "_fetch_ready_lo"}, a_fetch_ready, 0);
    for (int k = 0; k < len; k++) begin
      if (bubble && k == 1) begin
        ld_valid = 1'b0;
        @(negedge clk);
        check({tag, "_bubble_no_done"}, a_ld_done, 0);
        check({tag, "_bubble_busy"}, a_busy, 1);
      end
      ld_valid = 1'b1;
      ld_data  = words[k];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check({tag, "_done_a"}, a_ld_done, 1);
    check({tag, "_done_b"}, b_ld_done, 1);
    check({tag, "_idle_ready"}, a_fetch_ready, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, a_ld_done, 0);
  endtask

  initial begin
    vecs[0]  = '{8'd0,   16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{8'd255, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{8'd10,  16'h0012, 1'b0, 16'h0012, 1'b0};
    vecs[3]  = '{8'd11,  16'h0034, 1'b0, 16'h0034, 1'b0};
    vecs[4]  = '{8'd12,  16'h0056, 1'b0, 16'h0056, 1'b0};
    vecs[5]  = '{8'd13,  16'h0078, 1'b0, 16'h0078, 1'b0};
    vecs[6]  = '{8'd198, 16'h0001, 1'b0, 16'h0001, 1'b0};
    vecs[7]  = '{8'd199, 16'h0002, 1'b0, 16'h0002, 1'b0};
    vecs[8]  = '{8'd0,   16'h0000, 1'b0, 16'h0003, 1'b0};
    vecs[9]  = '{8'd1,   16'h0000, 1'b0, 16'h0004, 1'b0};
    vecs[10] = '{8'd200, 16'h0003, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{8'd201, 16'h0004, 1'b0, 16'h0000, 1'b1};
    vecs[12] = '{8'd10,  16'h9012, 1'b0, 16'h9012, 1'b0};
    vecs[13] = '{8'd10,  16'h0000, 1'b0, 16'h0000, 1'b0};

    reset = 1'b0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
    ld_valid = 1'b0; ld_data = '0; fetch_req = 1'b0; fetch_addr = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 1);
    check("rst_ld_ready", a_ld_ready, 0);
    check("rst_ld_done", a_ld_done, 0);
    check("rst_fetch_ready", a_fetch_ready, 0);
    check("rst_fetch_valid", a_fetch_valid, 0);
    check("rst_fetch_err", a_fetch_err, 0);
    check("rst_instr", a_instr, 0);
    check("rst_c_instr", c_instr, 0);
    reset = 1'b1;
    scrub_wait("scrub");
    check("idle_fetch_ready", a_fetch_ready, 1);

    run_vecs(0, 1);

    // zero-length burst: done pulse, no LOAD
    @(negedge clk);
    ld_start = 1'b1; ld_base = 8'd10; ld_len = 9'd0;
    @(negedge clk);
    ld_start = 1'b0;
    check("len0_done", a_ld_done, 1);
    check("len0_busy", a_busy, 0);
    check("len0_ld_ready", a_ld_ready, 0);
    @(negedge clk);
    check("len0_pulse", a_ld_done, 0);

    words[0] = 16'h0012; words[1] = 16'h0034; words[2] = 16'h0056; words[3] = 16'h0078;
    do_load("ld10", 8'd10, 4, 1'b1);
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003; words[3] = 16'h0004;
    do_load("ld198", 8'd198, 4, 1'b0);

    run_vecs(2, 11);

    // ld_start and fetch in the same IDLE cycle; fetch sees pre-load contents
    @(negedge clk);
    ld_start = 1'b1; ld_base = 8'd10; ld_len = 9'd1;
    fetch_req = 1'b1; fetch_addr = 8'd10;
    @(negedge clk);
    ld_start = 1'b0; fetch_addr = 8'd11;
    ld_valid = 1'b1; ld_data = 16'h9012;
    check("same_a_valid", a_fetch_valid, 1);
    check("same_a_old", a_instr, 16'h0012);
    check("same_fetch_blocked", a_fetch_ready, 0);
    @(negedge clk);
    ld_valid = 1'b0; fetch_req = 1'b0;
    check("same_c_valid", c_fetch_valid, 1);
    check("same_c_old", c_instr, 16'h0012);
    check("load_fetch_ignored", a_fetch_valid, 0);
    check("same_done", a_ld_done, 1);

    run_vecs(12, 12);

    // reset in the middle of a burst
    @(negedge clk);
    ld_start = 1'b1; ld_base = 8'd10; ld_len = 9'd4;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'haaaa;
    @(negedge clk);
    ld_data = 16'hbbbb;
    @(negedge clk);
    ld_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", a_busy, 1);
    check("abort_ld_ready", a_ld_ready, 0);
    check("abort_ld_done", a_ld_done, 0);
    @(negedge clk);
    reset = 1'b1;
    scrub_wait("abort");

    run_vecs(13, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
